sbfram_arbiter: RTL

Arbiter and sequencer in front of the single-bit flat RAM, which has two write ports, two read ports and combinational reads. It shares the RAM's two port pairs among N requesters, granting up to two operations per cycle in round-robin order. It also runs a sequential clear sweep that zeroes the array two bits per cycle, so the RAM's bulk clear input can be tied low.

---
 rtl/sbfram_arb_pkg.sv | 12 +
 rtl/sbfram_arbiter_rr_pick2.sv | 61 ++++++
 rtl/sbfram_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sbfram_arb_pkg.sv
// Shared types and default sizes for the single-bit flat RAM arbiter.
package sbfram_arb_pkg;

  localparam int unsigned DEF_S = 20;
  localparam int unsigned DEF_N = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sbfram_arbiter_rr_pick2.sv
// Two-winner round-robin picker (combinational).
// Ports:
//   req       - per-requester request vector
//   conflict  - conflict[i][j]: requester j may not share a cycle with winner i
//   ptr       - round-robin start index
//   win0/1    - one-hot winners for slot 0 / slot 1
//   win0/1_vld, idx0/1 - winner valid flags and binary indices
module rr_pick2 #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  conflict [N],
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win0,
  output logic          win0_vld,
  output logic [PW-1:0] idx0,
  output logic [N-1:0]  win1,
  output logic          win1_vld,
  output logic [PW-1:0] idx1
);

  logic [N-1:0]  elig;
  logic [N-1:0]  conf_row;
  logic [PW-1:0] idx;
  int unsigned   sum;

  // First scan finds slot 0; second scan runs over the remaining, non-conflicting requesters.
  always_comb begin
    win0     = '0;
    win0_vld = 1'b0;
    idx0     = '0;
    win1     = '0;
    win1_vld = 1'b0;
    idx1     = '0;
    conf_row = '0;
    idx      = '0;
    sum      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = 32'(ptr) + k;
      idx = PW'((sum >= N) ? sum - N : sum);
      if (!win0_vld && req[idx]) begin
        win0[idx] = 1'b1;
        win0_vld  = 1'b1;
        idx0      = idx;
        conf_row  = conflict[idx];
      end
    end
    elig = req & ~win0 & ~conf_row;
    for (int unsigned k = 0; k < N; k++) begin
      sum = 32'(ptr) + k;
      idx = PW'((sum >= N) ? sum - N : sum);
      if (!win1_vld && elig[idx]) begin
        win1[idx] = 1'b1;
        win1_vld  = 1'b1;
        idx1      = idx;
      end
    end
  end

endmodule

// File: rtl/sbfram_arbiter.sv
// Arbiter/sequencer for a 2W/2R single-bit flat RAM with combinational reads.
// Shares the two RAM port pairs among N requesters (up to two ops per cycle,
// round-robin) and runs a two-bits-per-cycle clear sweep.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   req/we/addr/wdata          - per-requester request, op type (1=write), address, write bit
//   gnt                        - combinational grant; op executes in the grant cycle
//   rvalid/rdata               - registered read return, one cycle after the grant
//   clr_start/clr_busy/clr_done- clear sweep control and status
//   ram_*                      - RAM write ports, read addresses and read data
module sbfram_arbiter
  import sbfram_arb_pkg::*;
#(
  parameter int unsigned S = DEF_S,
  parameter int unsigned N = DEF_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   we,
  input  logic [N*S-1:0] addr,
  input  logic [N-1:0]   wdata,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rvalid,
  output logic [N-1:0]   rdata,
  input  logic           clr_start,
  output logic           clr_busy,
  output logic           clr_done,
  output logic           ram_wr_en_0,
  output logic [S-1:0]   ram_wr_addr_0,
  output logic           ram_wr_data_0,
  output logic           ram_wr_en_1,
  output logic [S-1:0]   ram_wr_addr_1,
  output logic           ram_wr_data_1,
  output logic [S-1:0]   ram_rd_addr_0,
  output logic [S-1:0]   ram_rd_addr_1,
  input  logic           ram_rd_data_0,
  input  logic           ram_rd_data_1
);

  localparam int unsigned PW = $clog2(N);
  // Last even sweep address, 2**S - 2.
  localparam logic [S-1:0] CNT_LAST = ~S'(1);

  arb_state_e    state, next_state;
  logic [PW-1:0] ptr, ptr_next;
  logic [S-1:0]  cnt, cnt_next;
  logic [N-1:0]  rd0, rd1;
  logic [N-1:0]  rdata_next;
  logic          done_next;

  logic [S-1:0]  addr_a   [N];
  logic [N-1:0]  conflict [N];
  logic [N-1:0]  win0, win1;
  logic          win0_vld, win1_vld, v0, v1;
  logic [PW-1:0] idx0, idx1;

  // Unpack addresses and build the write-write same-address conflict matrix.
  for (genvar g = 0; g < N; g++) begin : g_addr
    assign addr_a[g] = addr[g*S +: S];
  end
  for (genvar g = 0; g < N; g++) begin : g_conf_row
    for (genvar h = 0; h < N; h++) begin : g_conf_col
      assign conflict[g][h] = we[g] & we[h] & (addr_a[g] == addr_a[h]);
    end
  end

  rr_pick2 #(.N(N)) u_pick (
    .req      (req),
    .conflict (conflict),
    .ptr      (ptr),
    .win0     (win0),
    .win0_vld (win0_vld),
    .idx0     (idx0),
    .win1     (win1),
    .win1_vld (win1_vld),
    .idx1     (idx1)
  );

  // Grants are suppressed entirely while reset is asserted.
  assign v0 = win0_vld & rst_n;
  assign v1 = win1_vld & rst_n;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N - 1)) ? '0 : p + PW'(1);
  endfunction

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      rdata    <= '0;
      rvalid   <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= next_state;
      ptr      <= ptr_next;
      cnt      <= cnt_next;
      rdata    <= rdata_next;
      rvalid   <= rd0 | rd1;
      clr_busy <= (next_state == SWEEP);
      clr_done <= done_next;
    end
  end

  // Next-state, grant and RAM port muxing.
  always_comb begin
    next_state    = state;
    ptr_next      = ptr;
    cnt_next      = cnt;
    done_next     = 1'b0;
    gnt           = '0;
    rd0           = '0;
    rd1           = '0;
    ram_wr_en_0   = 1'b0;
    ram_wr_addr_0 = '0;
    ram_wr_data_0 = 1'b0;
    ram_wr_en_1   = 1'b0;
    ram_wr_addr_1 = '0;
    ram_wr_data_1 = 1'b0;
    ram_rd_addr_0 = '0;
    ram_rd_addr_1 = '0;
    case (state)
      IDLE: begin
        if (v0) begin
          gnt = gnt | win0;
          if (we[idx0]) begin
            ram_wr_en_0   = 1'b1;
            ram_wr_addr_0 = addr_a[idx0];
            ram_wr_data_0 = wdata[idx0];
          end else begin
            ram_rd_addr_0 = addr_a[idx0];
            rd0           = win0;
          end
        end
        if (v1) begin
          gnt = gnt | win1;
          if (we[idx1]) begin
            ram_wr_en_1   = 1'b1;
            ram_wr_addr_1 = addr_a[idx1];
            ram_wr_data_1 = wdata[idx1];
          end else begin
            ram_rd_addr_1 = addr_a[idx1];
            rd1           = win1;
          end
        end
        // Pointer moves past the last requester granted this cycle.
        if (v1) begin
          ptr_next = ptr_inc(idx1);
        end else if (v0) begin
          ptr_next = ptr_inc(idx0);
        end
        if (clr_start) begin
          next_state = SWEEP;
          cnt_next   = '0;
        end
      end
      SWEEP: begin
        ram_wr_en_0   = 1'b1;
        ram_wr_addr_0 = cnt;
        ram_wr_en_1   = 1'b1;
        ram_wr_addr_1 = cnt + S'(1);
        if (cnt == CNT_LAST) begin
          next_state = IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt + S'(2);
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Read captures only touch the bits read this cycle; other bits hold.
  assign rdata_next = (rdata & ~(rd0 | rd1))
                    | (rd0 & {N{ram_rd_data_0}})
                    | (rd1 & {N{ram_rd_data_1}});

endmodule
